// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl
//   Next-PC sequencer for the fetch stage. Arbitrates the redirect sources
//   (EX mispredict recovery, JR resolved in EX, direct jump at fetch and
//   BTB-predicted taken) against the HDU stall and the external fetch hold.
//   It drives the PC mux select, the PC and IF/ID write enables and the
//   IF/ID flush.
//
//   Redirects that arrive while fetch is held are parked in a one-entry
//   pending slot and applied on release. After an EX-class redirect, a
//   short RECOVER window blanks wrong-path jump and prediction requests.
//
//   Outputs are combinational from the current state and the inputs.
//   State, pending slot and event counters are registered.
module fetch_redirect_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_stall_req,
  input  logic             i_fetch_hold,
  input  logic             i_ex_mispredict,
  input  logic             i_ex_taken,
  input  logic             i_jr_req,
  input  logic             i_d_jump_req,
  input  logic             i_f_pred_taken,
  output logic [2:0]       o_pc_sel,
  output logic             o_pc_write,
  output logic             o_ifid_write,
  output logic             o_flush_ifid,
  output logic             o_busy_recover,
  output logic [CNT_W-1:0] o_mispredict_cnt,
  output logic [CNT_W-1:0] o_jr_cnt,
  output logic [CNT_W-1:0] o_stall_cnt
);

  // Sequencer states.
  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_HOLD    = 2'd1;
  localparam logic [1:0] ST_RECOVER = 2'd2;

  // PC mux select encodings.
  localparam logic [2:0] SEL_PC1  = 3'd0;  // PC+1
  localparam logic [2:0] SEL_BTBF = 3'd1;  // BTB target of fetch instruction
  localparam logic [2:0] SEL_BTBE = 3'd2;  // BTB target of EX branch (taken)
  localparam logic [2:0] SEL_PCE1 = 3'd3;  // PC_E+1 (EX branch not taken)
  localparam logic [2:0] SEL_JUMP = 3'd4;  // direct jump target
  localparam logic [2:0] SEL_JR   = 3'd5;  // JR target

  // The recovery countdown only needs to hold values up to FLUSH_CYCLES.
  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_RELOAD = CW'(FLUSH_CYCLES);
  localparam logic          NO_FLUSH   = (FLUSH_CYCLES == 0);

  // Priority rank of a select code. Higher wins. Both mispredict
  // recovery targets share the top rank.
  function automatic logic [2:0] sel_prio(input logic [2:0] sel);
    logic [2:0] p;
    case (sel)
      SEL_BTBE, SEL_PCE1: p = 3'd4;
      SEL_JR:             p = 3'd3;
      SEL_JUMP:           p = 3'd2;
      SEL_BTBF:           p = 3'd1;
      default:            p = 3'd0;
    endcase
    return p;
  endfunction

  // EX-class redirects start or restart the recovery window.
  function automatic logic sel_is_ex(input logic [2:0] sel);
    logic r;
    case (sel)
      SEL_BTBE, SEL_PCE1, SEL_JR: r = 1'b1;
      default:                    r = 1'b0;
    endcase
    return r;
  endfunction

  // Saturating increment: sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == {CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + CNT_W'(1);
    end
    return r;
  endfunction

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;      // recovery countdown, kept frozen while held
  logic [2:0]       r_pend_sel; // parked redirect; nonzero only in HOLD
  logic [CNT_W-1:0] r_mispredict_cnt;
  logic [CNT_W-1:0] r_jr_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic [2:0]       w_live_ex_sel;
  logic [2:0]       w_live_sel;
  logic [2:0]       w_cand_sel;
  logic [2:0]       w_rel_sel;
  logic [2:0]       w_apply_sel;
  logic             w_flush_win;
  logic [1:0]       w_state_nx;
  logic [CW-1:0]    w_cnt_nx;
  logic [2:0]       w_pend_nx;

  // Priority-encode the live redirect requests. The EX-only view is
  // kept separate so the flush window can blank the fetch-side requests.
  always_comb begin
    w_live_ex_sel = SEL_PC1;
    w_live_sel    = SEL_PC1;
    if (i_ex_mispredict) begin
      w_live_ex_sel = i_ex_taken ? SEL_BTBE : SEL_PCE1;
    end else if (i_jr_req) begin
      w_live_ex_sel = SEL_JR;
    end else begin
      w_live_ex_sel = SEL_PC1;
    end
    if (w_live_ex_sel != SEL_PC1) begin
      w_live_sel = w_live_ex_sel;
    end else if (i_d_jump_req) begin
      w_live_sel = SEL_JUMP;
    end else if (i_f_pred_taken) begin
      w_live_sel = SEL_BTBF;
    end else begin
      w_live_sel = SEL_PC1;
    end
  end

  // Choose the redirect that would be applied this cycle. A nonzero
  // countdown means a recovery window is open (live or frozen by a hold),
  // so only EX-class requests are eligible. Pending is empty outside
  // HOLD, so the release arbitration also covers RUN and RECOVER.
  always_comb begin
    w_flush_win = (r_cnt != {CW{1'b0}});
    w_cand_sel  = w_flush_win ? w_live_ex_sel : w_live_sel;
    if (sel_prio(w_cand_sel) > sel_prio(r_pend_sel)) begin
      w_rel_sel = w_cand_sel;
    end else begin
      w_rel_sel = r_pend_sel;
    end
    if (i_fetch_hold) begin
      w_apply_sel = SEL_PC1;
    end else begin
      w_apply_sel = w_rel_sel;
    end
  end

  // Drive the fetch controls from reset, hold and the applied redirect.
  always_comb begin
    o_pc_sel       = SEL_PC1;
    o_pc_write     = 1'b0;
    o_ifid_write   = 1'b0;
    o_flush_ifid   = 1'b0;
    o_busy_recover = 1'b0;
    if (reset) begin
      o_flush_ifid = 1'b1;
    end else begin
      o_busy_recover = (r_state == ST_RECOVER);
      if (i_fetch_hold) begin
        o_pc_sel     = SEL_PC1;
        o_pc_write   = 1'b0;
        o_ifid_write = 1'b0;
        o_flush_ifid = 1'b0;
      end else begin
        o_pc_sel = w_apply_sel;
        case (w_apply_sel)
          SEL_PC1: begin
            o_pc_write   = ~i_stall_req;
            o_ifid_write = ~i_stall_req;
            o_flush_ifid = 1'b0;
          end
          SEL_BTBF: begin
            // A prediction keeps the fetched instruction, so nothing is flushed.
            o_pc_write   = 1'b1;
            o_ifid_write = 1'b1;
            o_flush_ifid = 1'b0;
          end
          default: begin
            // Any other redirect makes the instruction in fetch wrong-path,
            // including one frozen by a stall.
            o_pc_write   = 1'b1;
            o_ifid_write = 1'b0;
            o_flush_ifid = 1'b1;
          end
        endcase
      end
    end
  end

  // Next-state, countdown and pending-slot logic.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_pend_nx  = r_pend_sel;
    if (i_fetch_hold) begin
      // Park the request. An equal- or higher-ranked request replaces it.
      w_state_nx = ST_HOLD;
      w_cnt_nx   = r_cnt;
      if ((w_cand_sel != SEL_PC1) &&
          (sel_prio(w_cand_sel) >= sel_prio(r_pend_sel))) begin
        w_pend_nx = w_cand_sel;
      end else begin
        w_pend_nx = r_pend_sel;
      end
    end else begin
      w_pend_nx = SEL_PC1;
      if (sel_is_ex(w_apply_sel)) begin
        if (NO_FLUSH) begin
          w_state_nx = ST_RUN;
          w_cnt_nx   = {CW{1'b0}};
        end else begin
          w_state_nx = ST_RECOVER;
          w_cnt_nx   = CNT_RELOAD;
        end
      end else begin
        case (r_state)
          ST_RUN: begin
            w_state_nx = ST_RUN;
            w_cnt_nx   = {CW{1'b0}};
          end
          ST_RECOVER: begin
            if (r_cnt <= CW'(1)) begin
              w_state_nx = ST_RUN;
              w_cnt_nx   = {CW{1'b0}};
            end else begin
              w_state_nx = ST_RECOVER;
              w_cnt_nx   = r_cnt - CW'(1);
            end
          end
          ST_HOLD: begin
            // Resume an interrupted recovery with its saved count.
            if (w_flush_win) begin
              w_state_nx = ST_RECOVER;
            end else begin
              w_state_nx = ST_RUN;
            end
            w_cnt_nx = r_cnt;
          end
          default: begin
            w_state_nx = ST_RUN;
            w_cnt_nx   = {CW{1'b0}};
          end
        endcase
      end
    end
  end

  // Register state, countdown and pending slot. Reset drops any parked redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_RUN;
      r_cnt      <= {CW{1'b0}};
      r_pend_sel <= SEL_PC1;
    end else begin
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      r_pend_sel <= w_pend_nx;
    end
  end

  // Saturating event counters. They count only redirects that are applied
  // and cycles in which the PC is frozen.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mispredict_cnt <= {CNT_W{1'b0}};
      r_jr_cnt         <= {CNT_W{1'b0}};
      r_stall_cnt      <= {CNT_W{1'b0}};
    end else begin
      if ((w_apply_sel == SEL_BTBE) || (w_apply_sel == SEL_PCE1)) begin
        r_mispredict_cnt <= sat_inc(r_mispredict_cnt);
      end else begin
        r_mispredict_cnt <= r_mispredict_cnt;
      end
      if (w_apply_sel == SEL_JR) begin
        r_jr_cnt <= sat_inc(r_jr_cnt);
      end else begin
        r_jr_cnt <= r_jr_cnt;
      end
      if (!o_pc_write) begin
        r_stall_cnt <= sat_inc(r_stall_cnt);
      end else begin
        r_stall_cnt <= r_stall_cnt;
      end
    end
  end

  assign o_mispredict_cnt = r_mispredict_cnt;
  assign o_jr_cnt         = r_jr_cnt;
  assign o_stall_cnt      = r_stall_cnt;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed bench for fetch_redirect_ctrl. Three instances share the input
// stimulus: a default build (a_), FLUSH_CYCLES=3 (b_) and CNT_W=2 (c_).
// Inputs change on the falling edge. Combinational outputs are sampled
// 1 time unit later. Counters are read on the falling edge after the
// rising edge that updates them.
module tb_fetch_redirect_ctrl;

  logic clk, reset;
  logic stall, hold, mis, taken, jr, dj, pred;

  logic [2:0]  a_sel, b_sel, c_sel;
  logic        a_pcw, a_ifw, a_fl, a_busy;
  logic        b_pcw, b_ifw, b_fl, b_busy;
  logic        c_pcw, c_ifw, c_fl, c_busy;
  logic [15:0] a_mc, a_jc, a_sc, b_mc, b_jc, b_sc;
  logic [1:0]  c_mc, c_jc, c_sc;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_redirect_ctrl #(.FLUSH_CYCLES(1), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .i_stall_req(stall), .i_fetch_hold(hold),
    .i_ex_mispredict(mis), .i_ex_taken(taken), .i_jr_req(jr), .i_d_jump_req(dj),
    .i_f_pred_taken(pred), .o_pc_sel(a_sel), .o_pc_write(a_pcw), .o_ifid_write(a_ifw),
    .o_flush_ifid(a_fl), .o_busy_recover(a_busy), .o_mispredict_cnt(a_mc),
    .o_jr_cnt(a_jc), .o_stall_cnt(a_sc));

  fetch_redirect_ctrl #(.FLUSH_CYCLES(3), .CNT_W(16)) dut_b (
    .clk(clk), .reset(reset), .i_stall_req(stall), .i_fetch_hold(hold),
    .i_ex_mispredict(mis), .i_ex_taken(taken), .i_jr_req(jr), .i_d_jump_req(dj),
    .i_f_pred_taken(pred), .o_pc_sel(b_sel), .o_pc_write(b_pcw), .o_ifid_write(b_ifw),
    .o_flush_ifid(b_fl), .o_busy_recover(b_busy), .o_mispredict_cnt(b_mc),
    .o_jr_cnt(b_jc), .o_stall_cnt(b_sc));

  fetch_redirect_ctrl #(.FLUSH_CYCLES(1), .CNT_W(2)) dut_c (
    .clk(clk), .reset(reset), .i_stall_req(stall), .i_fetch_hold(hold),
    .i_ex_mispredict(mis), .i_ex_taken(taken), .i_jr_req(jr), .i_d_jump_req(dj),
    .i_f_pred_taken(pred), .o_pc_sel(c_sel), .o_pc_write(c_pcw), .o_ifid_write(c_ifw),
    .o_flush_ifid(c_fl), .o_busy_recover(c_busy), .o_mispredict_cnt(c_mc),
    .o_jr_cnt(c_jc), .o_stall_cnt(c_sc));

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Backstop so a stuck run still ends.
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic clr();
    stall = 1'b0; hold = 1'b0; mis = 1'b0; taken = 1'b0;
    jr = 1'b0; dj = 1'b0; pred = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    clr();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clr();
    reset = 1'b1;
    @(negedge clk);
    #1;
    n_tests++; if ({a_sel, a_pcw, a_ifw, a_fl, a_busy} !== 7'b000_0010) begin n_fail++; $display("FAIL rst_outs got %b want 0000010", {a_sel, a_pcw, a_ifw, a_fl, a_busy}); end
    tick();
    tick();
    reset = 1'b0;
    #1;
    n_tests++; if ({a_sel, a_pcw, a_ifw, a_fl, a_busy} !== 7'b000_1100) begin n_fail++; $display("FAIL idle_outs got %b want 0001100", {a_sel, a_pcw, a_ifw, a_fl, a_busy}); end
    n_tests++; if ({a_mc, a_jc, a_sc} !== 48'd0) begin n_fail++; $display("FAIL rst_cnts got %0d/%0d/%0d want 0/0/0", a_mc, a_jc, a_sc); end
  endtask

  task automatic test_priority();
    do_reset();
    mis = 1'b1; taken = 1'b0; dj = 1'b1; pred = 1'b1;
    #1;
    n_tests++; if (a_sel !== 3'd3) begin n_fail++; $display("FAIL prio_mis_sel got %0d want 3", a_sel); end
    n_tests++; if ({a_pcw, a_ifw, a_fl} !== 3'b101) begin n_fail++; $display("FAIL prio_mis_ctl got %b want 101", {a_pcw, a_ifw, a_fl}); end
    tick();
    n_tests++; if (a_mc !== 16'd1) begin n_fail++; $display("FAIL prio_mis_cnt got %0d want 1", a_mc); end
    n_tests++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL prio_busy got %0d want 1", a_busy); end
    mis = 1'b0; dj = 1'b0;
    #1;
    n_tests++; if ({a_sel, a_ifw, a_fl} !== 5'b000_10) begin n_fail++; $display("FAIL recover_blank got %b want 00010", {a_sel, a_ifw, a_fl}); end
    tick();
    #1;
    n_tests++; if ({a_busy, a_sel, a_ifw, a_fl} !== 6'b0_001_10) begin n_fail++; $display("FAIL pred_after got %b want 000110", {a_busy, a_sel, a_ifw, a_fl}); end
    dj = 1'b1;
    #1;
    n_tests++; if ({a_sel, a_ifw, a_fl} !== 5'b100_01) begin n_fail++; $display("FAIL jump_sel got %b want 10001", {a_sel, a_ifw, a_fl}); end
    tick();
    jr = 1'b1;
    #1;
    n_tests++; if (a_sel !== 3'd5) begin n_fail++; $display("FAIL jr_over_jump got %0d want 5", a_sel); end
    tick();
    clr();
    tick();
    mis = 1'b1; taken = 1'b1; jr = 1'b1;
    #1;
    n_tests++; if (a_sel !== 3'd2) begin n_fail++; $display("FAIL mis_over_jr got %0d want 2", a_sel); end
    tick();
    clr();
    n_tests++; if ({a_mc, a_jc} !== {16'd2, 16'd1}) begin n_fail++; $display("FAIL prio_cnts got %0d/%0d want 2/1", a_mc, a_jc); end
  endtask

  task automatic test_stall();
    do_reset();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++; if ({a_pcw, a_ifw, a_fl} !== 3'b000) begin n_fail++; $display("FAIL stall_ctl[%0d] got %b want 000", i, {a_pcw, a_ifw, a_fl}); end
      tick();
    end
    n_tests++; if (a_sc !== 16'd3) begin n_fail++; $display("FAIL stall_cnt got %0d want 3", a_sc); end
    jr = 1'b1;
    #1;
    n_tests++; if ({a_sel, a_pcw, a_ifw, a_fl} !== 6'b101_101) begin n_fail++; $display("FAIL stall_jr got %b want 101101", {a_sel, a_pcw, a_ifw, a_fl}); end
    tick();
    clr();
    n_tests++; if ({a_jc, a_sc} !== {16'd1, 16'd3}) begin n_fail++; $display("FAIL stall_jr_cnts got %0d/%0d want 1/3", a_jc, a_sc); end
  endtask

  task automatic test_hold();
    do_reset();
    hold = 1'b1; dj = 1'b1;
    #1;
    n_tests++; if ({a_sel, a_pcw, a_ifw, a_fl} !== 6'b000_000) begin n_fail++; $display("FAIL hold_ctl got %b want 000000", {a_sel, a_pcw, a_ifw, a_fl}); end
    tick();
    dj = 1'b0; mis = 1'b1; taken = 1'b1;
    #1;
    n_tests++; if (a_pcw !== 1'b0) begin n_fail++; $display("FAIL hold_mis_pcw got %0d want 0", a_pcw); end
    tick();
    n_tests++; if (a_mc !== 16'd0) begin n_fail++; $display("FAIL hold_deferred_cnt got %0d want 0", a_mc); end
    mis = 1'b0; taken = 1'b0; pred = 1'b1;
    tick();
    pred = 1'b0;
    tick();
    hold = 1'b0;
    #1;
    n_tests++; if ({a_sel, a_pcw, a_ifw, a_fl} !== 6'b010_101) begin n_fail++; $display("FAIL hold_release got %b want 010101", {a_sel, a_pcw, a_ifw, a_fl}); end
    tick();
    #1;
    n_tests++; if ({a_mc, a_jc, a_sc} !== {16'd1, 16'd0, 16'd4}) begin n_fail++; $display("FAIL hold_cnts got %0d/%0d/%0d want 1/0/4", a_mc, a_jc, a_sc); end
    n_tests++; if ({a_busy, a_sel} !== 4'b1_000) begin n_fail++; $display("FAIL hold_jump_gone got %b want 1000", {a_busy, a_sel}); end
    tick();
    hold = 1'b1; dj = 1'b1;
    tick();
    hold = 1'b0; dj = 1'b0;
    #1;
    n_tests++; if ({a_sel, a_fl} !== 4'b100_1) begin n_fail++; $display("FAIL hold_jump_release got %b want 1001", {a_sel, a_fl}); end
    tick();
    n_tests++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL jump_no_recover got %0d want 0", a_busy); end
  endtask

  task automatic test_recover_reload();
    do_reset();
    mis = 1'b1; taken = 1'b0;
    #1;
    n_tests++; if (b_sel !== 3'd3) begin n_fail++; $display("FAIL f3_mis_sel got %0d want 3", b_sel); end
    tick();
    clr();
    dj = 1'b1;
    #1;
    n_tests++; if ({b_busy, b_sel} !== 4'b1_000) begin n_fail++; $display("FAIL f3_jump_blank got %b want 1000", {b_busy, b_sel}); end
    tick();
    dj = 1'b0; jr = 1'b1;
    #1;
    n_tests++; if (b_sel !== 3'd5) begin n_fail++; $display("FAIL f3_jr_sel got %0d want 5", b_sel); end
    tick();
    clr();
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++; if (b_busy !== 1'b1) begin n_fail++; $display("FAIL f3_busy[%0d] got %0d want 1", i, b_busy); end
      tick();
    end
    #1;
    n_tests++; if (b_busy !== 1'b0) begin n_fail++; $display("FAIL f3_busy_end got %0d want 0", b_busy); end
    n_tests++; if ({b_mc, b_jc} !== {16'd1, 16'd1}) begin n_fail++; $display("FAIL f3_cnts got %0d/%0d want 1/1", b_mc, b_jc); end
  endtask

  task automatic test_saturate_reset_hold();
    do_reset();
    mis = 1'b1; taken = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    clr();
    n_tests++; if (c_mc !== 2'd3) begin n_fail++; $display("FAIL sat_cnt got %0d want 3", c_mc); end
    n_tests++; if (a_mc !== 16'd5) begin n_fail++; $display("FAIL wide_cnt got %0d want 5", a_mc); end
    hold = 1'b1; jr = 1'b1;
    tick();
    jr = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    n_tests++; if ({c_sel, c_pcw, c_ifw, c_fl, c_busy} !== 7'b000_0010) begin n_fail++; $display("FAIL rst_in_hold got %b want 0000010", {c_sel, c_pcw, c_ifw, c_fl, c_busy}); end
    tick();
    reset = 1'b0; hold = 1'b0;
    #1;
    n_tests++; if ({c_sel, c_pcw, c_ifw, c_fl, c_busy} !== 7'b000_1100) begin n_fail++; $display("FAIL after_rst got %b want 0001100", {c_sel, c_pcw, c_ifw, c_fl, c_busy}); end
    tick();
    n_tests++; if ({c_mc, c_jc} !== 4'b00_00) begin n_fail++; $display("FAIL pend_dropped got %0d/%0d want 0/0", c_mc, c_jc); end
  endtask

  initial begin
    clr();
    reset = 1'b1;
    test_reset();
    test_priority();
    test_stall();
    test_hold();
    test_recover_reload();
    test_saturate_reset_hold();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
